// File: rtl/div_pkg.sv
// Shared constants for the sequential divider: FSM state encoding and default width.
package div_pkg;

  localparam int STATE_W   = 2;
  localparam int DEF_WIDTH = 8;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_datapath.sv
// Restoring shift-subtract datapath: R/Q/D registers, trial subtractor, optional sign fix.
// Signed operation is compiled in with SEQ_DIVIDER_SIGNED_EN.
module div_datapath #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             fix,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             dz
);

  logic [WIDTH-1:0] q_r, r_r, d_r;
  logic             dz_r;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] q_step, r_step, q_fin, r_fin;
  logic [WIDTH-1:0] a_ld, b_ld;

  always_comb begin
    trial = {r_r, q_r[WIDTH-1]} - {1'b0, d_r};
    if (!trial[WIDTH]) begin
      r_step = trial[WIDTH-1:0];
      q_step = {q_r[WIDTH-2:0], 1'b1};
    end else begin
      r_step = {r_r[WIDTH-2:0], q_r[WIDTH-1]};
      q_step = {q_r[WIDTH-2:0], 1'b0};
    end
  end

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic sign_q, sign_r;

  // Magnitudes go through the unsigned core; -2^(W-1) stays as its unsigned pattern.
  always_comb begin
    a_ld  = dividend[WIDTH-1] ? -dividend : dividend;
    b_ld  = divisor[WIDTH-1]  ? -divisor  : divisor;
    q_fin = (fix && sign_q) ? -q_step : q_step;
    r_fin = (fix && sign_r) ? -r_step : r_step;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign_q <= 1'b0;
      sign_r <= 1'b0;
    end else if (load) begin
      sign_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      sign_r <= dividend[WIDTH-1];
    end
  end
`else
  logic unused_fix;
  assign unused_fix = fix;

  always_comb begin
    a_ld  = dividend;
    b_ld  = divisor;
    q_fin = q_step;
    r_fin = r_step;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r  <= '0;
      r_r  <= '0;
      d_r  <= '0;
      dz_r <= 1'b0;
    end else if (load) begin
      d_r <= divisor;
      if (divisor == '0) begin
        dz_r <= 1'b1;
        q_r  <= '1;
        r_r  <= dividend;
      end else begin
        dz_r <= 1'b0;
        q_r  <= a_ld;
        r_r  <= '0;
        d_r  <= b_ld;
      end
    end else if (step) begin
      q_r <= q_fin;
      r_r <= r_fin;
    end
  end

  assign quotient  = q_r;
  assign remainder = r_r;
  assign dz        = dz_r;

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle divider top: St/Idle/Done controller driving div_datapath.
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             St,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic             Idle,
  output logic             Done,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             Dz
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             load, step, fix;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    load      = 1'b0;
    step      = 1'b0;
    fix       = 1'b0;
    case (state)
      S_IDLE: begin
        if (St) begin
          load      = 1'b1;
          cnt_nxt   = CNT_W'(WIDTH - 1);
          // A zero divisor is resolved at load time, so RUN is skipped.
          state_nxt = (Divisor == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        step = 1'b1;
        if (cnt == '0) begin
          fix       = 1'b1;
          state_nxt = S_DONE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign Idle = (state == S_IDLE);
  assign Done = (state == S_DONE);

  div_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk      (Clk),
    .rst      (Rst),
    .load     (load),
    .step     (step),
    .fix      (fix),
    .dividend (Dividend),
    .divisor  (Divisor),
    .quotient (Quotient),
    .remainder(Remainder),
    .dz       (Dz)
  );

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed cases, random divisions, reset and back-to-back.
module tb_seq_divider;

  localparam int W = 8;

  logic         Clk = 1'b0;
  logic         Rst = 1'b1;
  logic         St = 1'b0;
  logic [W-1:0] Dividend = '0;
  logic [W-1:0] Divisor = '0;
  logic         Idle, Done, Dz;
  logic [W-1:0] Quotient, Remainder;

  int n_checks = 0;
  int n_fail   = 0;

  seq_divider #(.WIDTH(W)) dut (
    .Clk(Clk), .Rst(Rst), .St(St), .Dividend(Dividend), .Divisor(Divisor),
    .Idle(Idle), .Done(Done), .Quotient(Quotient), .Remainder(Remainder), .Dz(Dz)
  );

  always #5 Clk = ~Clk;

  // Reference: plain arithmetic on the operands.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output logic dz);
    int sa, sb, tq, tr;
    if (b == 0) begin
      q = '1; r = a; dz = 1'b1;
    end else begin
`ifdef SEQ_DIVIDER_SIGNED_EN
      sa = int'($signed(a));
      sb = int'($signed(b));
`else
      sa = int'(a);
      sb = int'(b);
`endif
      tq = sa / sb;
      tr = sa % sb;
      q  = tq[W-1:0];
      r  = tr[W-1:0];
      dz = 1'b0;
    end
  endfunction

  // Launch one division with a single St pulse; returns edges from start to Done (-1 on timeout).
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output bit idle_seen);
    @(negedge Clk);
    Dividend = a; Divisor = b; St = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    St = 1'b0; Dividend = W'($urandom); Divisor = W'($urandom);
    lat = 0; idle_seen = 0;
    while (!Done && lat < 40) begin
      if (Idle) idle_seen = 1;
      @(negedge Clk);
      lat++;
    end
    if (!Done) lat = -1;
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if (Idle !== 1'b1 || Done !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: Idle=%b Done=%b expected Idle=1 Done=0", Idle, Done);
    end
    n_checks++;
    if (Quotient !== '0 || Remainder !== '0 || Dz !== 1'b0) begin
      n_fail++; $display("FAIL reset_outputs: Q=%h R=%h Dz=%b expected 0 0 0", Quotient, Remainder, Dz);
    end
    @(negedge Clk); Rst = 1'b0;
    repeat (2) @(negedge Clk);
    n_checks++;
    if (Idle !== 1'b1 || Done !== 1'b0) begin
      n_fail++; $display("FAIL idle_after_reset: Idle=%b Done=%b expected 1 0", Idle, Done);
    end
  endtask

  task automatic test_directed();
    int lat; bit idl;
    run_div(8'd100, 8'd7, lat, idl);
    n_checks++;
    if (lat !== W) begin n_fail++; $display("FAIL lat_100_7: got %0d expected %0d", lat, W); end
    n_checks++;
    if (idl) begin n_fail++; $display("FAIL idle_busy_100_7: Idle seen 1 expected 0"); end
    n_checks++;
    if (Idle !== 1'b0) begin n_fail++; $display("FAIL idle_with_done: got %b expected 0", Idle); end
    n_checks++;
    if (Quotient !== 8'd14 || Remainder !== 8'd2 || Dz !== 1'b0) begin
      n_fail++; $display("FAIL res_100_7: Q=%0d R=%0d Dz=%b expected 14 2 0", Quotient, Remainder, Dz);
    end
    @(negedge Clk);
    n_checks++;
    if (Done !== 1'b0 || Idle !== 1'b1) begin
      n_fail++; $display("FAIL done_pulse: Done=%b Idle=%b expected 0 1", Done, Idle);
    end
    repeat (3) @(negedge Clk);
    n_checks++;
    if (Quotient !== 8'd14 || Remainder !== 8'd2) begin
      n_fail++; $display("FAIL hold_100_7: Q=%0d R=%0d expected 14 2", Quotient, Remainder);
    end
    run_div(8'd255, 8'd1, lat, idl);
    n_checks++;
    if (Quotient !== 8'd255 || Remainder !== 8'd0 || lat !== W) begin
      n_fail++; $display("FAIL res_255_1: Q=%0d R=%0d lat=%0d expected 255 0 %0d", Quotient, Remainder, lat, W);
    end
    run_div(8'd5, 8'd9, lat, idl);
    n_checks++;
    if (Quotient !== 8'd0 || Remainder !== 8'd5) begin
      n_fail++; $display("FAIL res_5_9: Q=%0d R=%0d expected 0 5", Quotient, Remainder);
    end
    run_div(8'd200, 8'd200, lat, idl);
    n_checks++;
    if (Quotient !== 8'd1 || Remainder !== 8'd0) begin
      n_fail++; $display("FAIL res_200_200: Q=%0d R=%0d expected 1 0", Quotient, Remainder);
    end
  endtask

  task automatic test_div_zero();
    int lat; bit idl;
    run_div(8'd42, 8'd0, lat, idl);
    n_checks++;
    if (lat !== 0) begin n_fail++; $display("FAIL lat_dz: got %0d expected 0", lat); end
    n_checks++;
    if (Dz !== 1'b1 || Quotient !== 8'hFF || Remainder !== 8'd42) begin
      n_fail++; $display("FAIL res_dz: Dz=%b Q=%h R=%0d expected 1 ff 42", Dz, Quotient, Remainder);
    end
    run_div(8'd9, 8'd3, lat, idl);
    n_checks++;
    if (Dz !== 1'b0 || Quotient !== 8'd3 || Remainder !== 8'd0) begin
      n_fail++; $display("FAIL dz_clear: Dz=%b Q=%0d R=%0d expected 0 3 0", Dz, Quotient, Remainder);
    end
  endtask

  task automatic test_async_reset();
    int lat; bit idl; bit done_seen;
    @(negedge Clk);
    Dividend = 8'd100; Divisor = 8'd7; St = 1'b1;
    @(posedge Clk);
    @(negedge Clk); St = 1'b0;
    repeat (4) @(posedge Clk);
    #2 Rst = 1'b1;
    #1;
    n_checks++;
    if (Idle !== 1'b1 || Done !== 1'b0 || Quotient !== '0 || Remainder !== '0 || Dz !== 1'b0) begin
      n_fail++; $display("FAIL async_rst: Idle=%b Done=%b Q=%h R=%h Dz=%b expected 1 0 0 0 0",
                         Idle, Done, Quotient, Remainder, Dz);
    end
    @(negedge Clk); Rst = 1'b0;
    done_seen = 0;
    repeat (12) begin
      @(negedge Clk);
      if (Done || !Idle) done_seen = 1;
    end
    n_checks++;
    if (done_seen) begin n_fail++; $display("FAIL no_done_after_rst: activity seen expected none"); end
    run_div(8'd100, 8'd7, lat, idl);
    n_checks++;
    if (Quotient !== 8'd14 || Remainder !== 8'd2 || lat !== W) begin
      n_fail++; $display("FAIL res_after_rst: Q=%0d R=%0d lat=%0d expected 14 2 %0d", Quotient, Remainder, lat, W);
    end
  endtask

  task automatic test_random();
    int lat; bit idl;
    logic [W-1:0] a, b, eq, er; logic edz;
    for (int i = 0; i < 24; i++) begin
      a = W'($urandom);
      b = (i % 6 == 5) ? '0 : W'($urandom);
      model(a, b, eq, er, edz);
      run_div(a, b, lat, idl);
      n_checks++;
      if (Quotient !== eq || Remainder !== er || Dz !== edz || lat !== (edz ? 0 : W)) begin
        n_fail++; $display("FAIL rand_%0d %h/%h: Q=%h R=%h Dz=%b lat=%0d expected %h %h %b %0d",
                           i, a, b, Quotient, Remainder, Dz, lat, eq, er, edz, edz ? 0 : W);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] opa [0:63];
    logic [W-1:0] opb [0:63];
    logic [W-1:0] eq, er; logic edz;
    int last_done, n_done, idle_cnt;
    last_done = -1; n_done = 0; idle_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge Clk);
      // Observed state is after edge c; edge c+1 samples what is driven below.
      if (Done) begin
        n_done++;
        model(opa[c-W], opb[c-W], eq, er, edz);
        n_checks++;
        if (Quotient !== eq || Remainder !== er || Dz !== edz) begin
          n_fail++; $display("FAIL b2b_res_%0d: Q=%h R=%h expected %h %h", n_done, Quotient, Remainder, eq, er);
        end
        n_checks++;
        if (last_done < 0 ? (c !== 1 + W) : (c - last_done !== W + 2)) begin
          n_fail++; $display("FAIL b2b_timing_%0d: done at cycle %0d, previous %0d", n_done, c, last_done);
        end
        if (last_done >= 0) begin
          n_checks++;
          if (idle_cnt !== 1) begin
            n_fail++; $display("FAIL b2b_idle_gap_%0d: got %0d idle cycles expected 1", n_done, idle_cnt);
          end
        end
        last_done = c; idle_cnt = 0;
      end else if (Idle && last_done >= 0) begin
        idle_cnt++;
      end
      Dividend = W'($urandom);
      Divisor  = W'($urandom_range(1, 255));
      St = (c < 25);
      opa[c+1] = Dividend; opb[c+1] = Divisor;
      @(posedge Clk);
    end
    n_checks++;
    if (n_done !== 3) begin n_fail++; $display("FAIL b2b_count: got %0d dones expected 3", n_done); end
    St = 1'b0;
  endtask

`ifdef SEQ_DIVIDER_SIGNED_EN
  task automatic test_signed();
    int lat; bit idl;
    run_div(8'h9C, 8'd7, lat, idl);
    n_checks++;
    if (Quotient !== 8'hF2 || Remainder !== 8'hFE || lat !== W) begin
      n_fail++; $display("FAIL s_m100_7: Q=%h R=%h lat=%0d expected f2 fe %0d", Quotient, Remainder, lat, W);
    end
    run_div(8'd100, 8'hF9, lat, idl);
    n_checks++;
    if (Quotient !== 8'hF2 || Remainder !== 8'h02) begin
      n_fail++; $display("FAIL s_100_m7: Q=%h R=%h expected f2 02", Quotient, Remainder);
    end
    run_div(8'h80, 8'hFF, lat, idl);
    n_checks++;
    if (Quotient !== 8'h80 || Remainder !== 8'h00 || Dz !== 1'b0) begin
      n_fail++; $display("FAIL s_m128_m1: Q=%h R=%h Dz=%b expected 80 00 0", Quotient, Remainder, Dz);
    end
    run_div(8'hF0, 8'd0, lat, idl);
    n_checks++;
    if (Quotient !== 8'hFF || Remainder !== 8'hF0 || Dz !== 1'b1) begin
      n_fail++; $display("FAIL s_dz: Q=%h R=%h Dz=%b expected ff f0 1", Quotient, Remainder, Dz);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_div_zero();
    test_async_reset();
    test_random();
    test_back_to_back();
`ifdef SEQ_DIVIDER_SIGNED_EN
    test_signed();
`endif
    repeat (2) @(negedge Clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
